wb_trace_checker: RTL

Simulation/FPGA-side consumer of the CPU debug write-back trace port (`debug_wb_pc`, `debug_wb_rf_wen`, `debug_wb_rf_addr`, `debug_wb_rf_wdata`). It holds a golden trace of register-file writes in an internal memory and compares each architectural write committed by the 5-stage core against the next expected entry. It reports pass/fail, error counts and the first mismatch. It sits beside `cpu` in the test harness and on the board-level debug wrapper.

---
 rtl/wb_trace_checker_if.sv | 22 ++
 rtl/wb_trace_checker.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/wb_trace_checker_if.sv
// CPU debug write-back trace bundle, as seen between the core and the trace checker.
// rf_wen qualifies the other three fields in the same cycle; there is no ready, so the consumer must take one write per cycle.
interface wb_trace_checker_if;
  logic [31:0] debug_wb_pc;
  logic        debug_wb_rf_wen;
  logic [4:0]  debug_wb_rf_addr;
  logic [31:0] debug_wb_rf_wdata;

  modport master (
    output debug_wb_pc,
    output debug_wb_rf_wen,
    output debug_wb_rf_addr,
    output debug_wb_rf_wdata
  );

  modport slave (
    input debug_wb_pc,
    input debug_wb_rf_wen,
    input debug_wb_rf_addr,
    input debug_wb_rf_wdata
  );
endinterface

// File: rtl/wb_trace_checker.sv
// Compares CPU register-file write-back commits against a golden trace held in a synchronous-read memory.
// Reports pass/fail, consumed entries, error count and details of the first mismatch.
module wb_trace_checker #(
  parameter int AW           = 10,
  parameter bit STOP_ON_FAIL = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ld_en,
  input  logic [AW-1:0]     ld_addr,
  input  logic [31:0]       ld_pc,
  input  logic [4:0]        ld_rf_addr,
  input  logic [31:0]       ld_rf_wdata,
  input  logic [AW:0]       trace_len,
  input  logic              start,
  wb_trace_checker_if.slave wb,
  output logic              busy,
  output logic              pass,
  output logic              fail,
  output logic [AW:0]       match_count,
  output logic [15:0]       err_count,
  output logic [AW:0]       fail_idx,
  output logic [31:0]       fail_pc,
  output logic [31:0]       fail_exp_pc,
  output logic [2:0]        state_dbg
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PRIME = 3'd1,
    ST_RUN   = 3'd2,
    ST_PASS  = 3'd3,
    ST_FAIL  = 3'd4
  } state_t;

  localparam int          DEPTH = 1 << AW;
  localparam logic [AW:0] ONE   = (AW+1)'(1);

  state_t      state, state_d;
  logic [AW:0] len_q, len_d;
  logic [AW:0] mc_d, mc_inc, fidx_d;
  logic [15:0] err_d, err_inc;
  logic [31:0] fpc_d, fexp_d;

  logic [68:0]   mem [DEPTH];
  logic [68:0]   rd_q;
  logic [AW-1:0] rd_addr;

  logic        idle_like, ld_wr, commit, hit, first_err;
  logic [31:0] exp_pc, exp_data;
  logic [4:0]  exp_addr;

  assign idle_like = (state == ST_IDLE) || (state == ST_PASS) || (state == ST_FAIL);
  assign ld_wr     = ld_en && idle_like;
  assign {exp_pc, exp_addr, exp_data} = rd_q;
  assign commit    = wb.debug_wb_rf_wen && (wb.debug_wb_rf_addr != 5'd0);
  assign hit       = (wb.debug_wb_pc == exp_pc) && (wb.debug_wb_rf_addr == exp_addr) &&
                     (wb.debug_wb_rf_wdata == exp_data);
  assign first_err = (err_count == 16'd0);
  assign err_inc   = (err_count == 16'hFFFF) ? err_count : err_count + 16'd1;
  assign mc_inc    = match_count + ONE;

  // Loads never overlap PRIME/RUN, so read-during-write ordering does not matter.
  always_ff @(posedge clk) begin
    if (ld_wr) begin
      mem[ld_addr] <= {ld_pc, ld_rf_addr, ld_rf_wdata};
    end
    rd_q <= mem[rd_addr];
  end

  always_comb begin
    state_d = state;
    len_d   = len_q;
    mc_d    = match_count;
    err_d   = err_count;
    fidx_d  = fail_idx;
    fpc_d   = fail_pc;
    fexp_d  = fail_exp_pc;
    rd_addr = match_count[AW-1:0];

    case (state)
      ST_IDLE, ST_PASS, ST_FAIL: begin
        if (start) begin
          state_d = ST_PRIME;
          len_d   = trace_len;
          mc_d    = '0;
          err_d   = '0;
          fidx_d  = '0;
          fpc_d   = '0;
          fexp_d  = '0;
        end else if ((state == ST_PASS) && commit) begin
          // Overrun: a write beyond the end of a clean trace.
          err_d   = err_inc;
          state_d = ST_FAIL;
          if (first_err) begin
            fidx_d = len_q;
            fpc_d  = wb.debug_wb_pc;
            fexp_d = '0;
          end
        end
      end
      ST_PRIME: begin
        rd_addr = '0;
        state_d = (len_q == '0) ? ST_PASS : ST_RUN;
      end
      ST_RUN: begin
        if (commit) begin
          mc_d    = mc_inc;
          rd_addr = mc_inc[AW-1:0];
          if (!hit) begin
            err_d = err_inc;
            if (first_err) begin
              fidx_d = match_count;
              fpc_d  = wb.debug_wb_pc;
              fexp_d = exp_pc;
            end
          end
          if (mc_inc == len_q) begin
            state_d = (err_d == 16'd0) ? ST_PASS : ST_FAIL;
          end else if (!hit && STOP_ON_FAIL) begin
            state_d = ST_FAIL;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      len_q       <= '0;
      match_count <= '0;
      err_count   <= '0;
      fail_idx    <= '0;
      fail_pc     <= '0;
      fail_exp_pc <= '0;
    end else begin
      state       <= state_d;
      len_q       <= len_d;
      match_count <= mc_d;
      err_count   <= err_d;
      fail_idx    <= fidx_d;
      fail_pc     <= fpc_d;
      fail_exp_pc <= fexp_d;
    end
  end

  assign busy      = (state == ST_PRIME) || (state == ST_RUN);
  assign pass      = (state == ST_PASS);
  assign fail      = (state == ST_FAIL);
  assign state_dbg = state;

endmodule
